// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the multi-cycle MIPS controller.
// State encoding, opcode/funct values, mux selects and the control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_EXEC_I,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_REG    = 2'd3;

  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;

  localparam logic [1:0] MR_ALU = 2'd0;
  localparam logic [1:0] MR_MDR = 2'd1;
  localparam logic [1:0] MR_PC  = 2'd2;

  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_4    = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM2 = 2'd3;

  localparam logic [1:0] AO_ADD   = 2'd0;
  localparam logic [1:0] AO_SUB   = 2'd1;
  localparam logic [1:0] AO_FUNCT = 2'd2;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) ||
           (op == OP_LW)    || (op == OP_SW)   ||
           (op == OP_BEQ)   || (op == OP_BNE)  ||
           (op == OP_J)     || (op == OP_JAL);
  endfunction

  // Dispatch out of DECODE; illegal opcodes fall back to FETCH.
  function automatic state_t decode_next(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    state_t s;
    s = S_FETCH;
    unique case (1'b1)
      op == OP_RTYPE && fn == FN_JR: s = S_JR;
      op == OP_RTYPE && fn != FN_JR: s = S_EXEC_R;
      op == OP_ADDI:                 s = S_EXEC_I;
      op == OP_LW || op == OP_SW:    s = S_MEM_ADDR;
      op == OP_BEQ || op == OP_BNE:  s = S_BRANCH;
      op == OP_J:                    s = S_JUMP;
      op == OP_JAL:                  s = S_JAL;
      default:                       s = S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational state-to-control map.
// FETCH qualifies ir_write/pc_write with mem_ready.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SB_4;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SB_IMM2;
        ctrl.illegal   = !is_legal(opcode);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_B;
        ctrl.alu_op    = AO_FUNCT;
      end
      S_WB_R: begin
        ctrl.reg_dst   = RD_RD;
        ctrl.reg_write = 1'b1;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SB_IMM;
      end
      S_WB_I: begin
        ctrl.reg_dst   = RD_RT;
        ctrl.reg_write = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.mem_to_reg = MR_MDR;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = AO_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
        ctrl.branch_ne     = opcode[0];
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = RD_RA;
        ctrl.mem_to_reg = MR_PC;
      end
      S_JR: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_REG;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle MIPS main controller.
// Sequences a shared-memory datapath and counts retired instructions.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int RA_REG = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  if (RA_REG < 0 || RA_REG > 31) begin : g_ra_check
    $error("RA_REG must index a register");
  end

  state_t state;
  state_t next;
  logic   retire;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    next   = state;
    retire = 1'b0;
    unique case (state)
      S_FETCH:    if (mem_ready) next = S_DECODE;
      S_DECODE:   next = decode_next(opcode, funct);
      S_EXEC_R:   next = S_WB_R;
      S_EXEC_I:   next = S_WB_I;
      S_MEM_ADDR: next = opcode[3] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) next = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          next   = S_FETCH;
          retire = 1'b1;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM,
      S_BRANCH, S_JUMP, S_JAL, S_JR: begin
        next   = S_FETCH;
        retire = 1'b1;
      end
      default: next = S_FETCH;
    endcase
  end

  mc_out_decode u_out (
    .state     (state),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign branch_ne     = ctrl.branch_ne;
  assign pc_src        = ctrl.pc_src;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign illegal       = ctrl.illegal;

endmodule
